// File: rtl/updown_counter_if.sv
// Data-side signals of updown_counter: direction select in, count and range flags out.
interface updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             UpOrDown;
    logic [WIDTH-1:0] Count;
    logic             tc;
    logic             at_max;
    logic             at_min;

    modport master (
        output UpOrDown,
        input  Count,
        input  tc,
        input  at_max,
        input  at_min
    );

    modport slave (
        input  UpOrDown,
        output Count,
        output tc,
        output at_max,
        output at_min
    );
endinterface

// File: rtl/updown_counter.sv
// Free-running up/down counter with terminal-count flag; wraps at the range ends
// by default, saturates when UPDOWN_SAT_EN is defined.
module updown_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic              Clk,
    input  logic              reset,
    updown_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] STEP  = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;
    logic             at_min;

    assign at_max = (count_q == CNT_MAX);
    assign at_min = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (bus.UpOrDown) begin
`ifdef UPDOWN_SAT_EN
            count_d = at_max ? count_q : count_q + STEP;
`else
            count_d = count_q + STEP;
`endif
        end else begin
`ifdef UPDOWN_SAT_EN
            count_d = at_min ? count_q : count_q - STEP;
`else
            count_d = count_q - STEP;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bus.Count  = count_q;
    assign bus.at_max = at_max;
    assign bus.at_min = at_min;
    assign bus.tc     = (bus.UpOrDown & at_max) | (~bus.UpOrDown & at_min);
endmodule

// File: tb/tb_updown_counter.sv
// Randomised and directed checks of updown_counter against an arithmetic reference model.
module tb_updown_counter;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned MAXV  = (1 << WIDTH) - 1;

    logic Clk;
    logic reset;

    int unsigned checks;
    int unsigned failures;
    int unsigned model;
    bit          model_valid;

    updown_counter_if #(.WIDTH(WIDTH)) bus ();

    updown_counter #(.WIDTH(WIDTH)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic dir;
        dir = bus.UpOrDown;
        check({tag, ".Count"},  32'(bus.Count),  model);
        check({tag, ".at_max"}, 32'(bus.at_max), 32'(model == MAXV));
        check({tag, ".at_min"}, 32'(bus.at_min), 32'(model == 0));
        check({tag, ".tc"},     32'(bus.tc),     32'(dir ? (model == MAXV) : (model == 0)));
    endtask

    // Drive inputs just after an edge, check the combinational tc, clock once, check all outputs.
    task automatic step(input logic r, input logic d, input string tag);
        reset = r;
        bus.UpOrDown = d;
        #1;
        if (model_valid)
            check({tag, ".tc_pre"}, 32'(bus.tc), 32'(d ? (model == MAXV) : (model == 0)));
        @(posedge Clk);
        if (!r) begin
            model = 0;
            model_valid = 1'b1;
        end else if (d) begin
`ifdef UPDOWN_SAT_EN
            model = (model == MAXV) ? MAXV : model + 1;
`else
            model = (model + 1) % (MAXV + 1);
`endif
        end else begin
`ifdef UPDOWN_SAT_EN
            model = (model == 0) ? 0 : model - 1;
`else
            model = (model + MAXV) % (MAXV + 1);
`endif
        end
        #1;
        if (model_valid) check_outputs(tag);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        model = 0;
        model_valid = 1'b0;
        reset = 1'b1;
        bus.UpOrDown = 1'b1;
        @(posedge Clk);
        #1;

        step(1'b0, 1'b1, "rst0");
        step(1'b0, 1'b1, "rst1");
        check("rst.Count_lit", 32'(bus.Count), 32'd0);
        check("rst.tc_lit", 32'(bus.tc), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1, "up_after_rst");
            check("up_after_rst.lit", 32'(bus.Count), 32'(i));
        end

        step(1'b0, 1'b1, "rst_wrap");
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, "up_wrap");
`ifdef UPDOWN_SAT_EN
        check("up16.lit", 32'(bus.Count), 32'd15);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "up_sat");
        check("up_sat.tc_lit", 32'(bus.tc), 32'd1);
        step(1'b1, 1'b0, "sat_rev");
        check("sat_rev.lit", 32'(bus.Count), 32'd14);
`else
        check("up16.lit", 32'(bus.Count), 32'd0);
`endif

        step(1'b0, 1'b1, "rst_down");
        step(1'b1, 1'b1, "to2");
        step(1'b1, 1'b1, "to2");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "down_wrap");
`ifdef UPDOWN_SAT_EN
        check("down.lit", 32'(bus.Count), 32'd0);
`else
        check("down.lit", 32'(bus.Count), 32'd14);
`endif

        step(1'b0, 1'b1, "rst_rev");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "to5");
        step(1'b1, 1'b0, "reverse");
        check("reverse.lit", 32'(bus.Count), 32'd4);

        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, "to9");
        check("to9.lit", 32'(bus.Count), 32'd9);
        step(1'b0, 1'b1, "mid_rst");
        check("mid_rst.lit", 32'(bus.Count), 32'd0);
        step(1'b1, 1'b1, "post_rst");
        check("post_rst.lit", 32'(bus.Count), 32'd1);

        for (int i = 0; i < 400; i++) begin
            logic r;
            logic d;
            r = ($urandom_range(0, 15) != 0);
            d = ($urandom_range(0, 3) != 0) ^ (i >= 200);
            step(r, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
